ascii_scroll_display: RTL and testbench
=======================================

# ascii_scroll_display

Multi-digit, time-multiplexed ASCII text driver for the 7-segment output path. Characters enter a circular buffer through a valid/ready write port. The buffer contents are either shown statically or scrolled right-to-left across NUM_DIGITS multiplexed digits. The block replaces single-character decoding at the top level: it drives the shared segment bus and one-hot digit enables directly.

## Interface
- NUM_DIGITS, 4: number of physical digits, ≥1.
- BUF_DEPTH, 16: character buffer entries, ≥NUM_DIGITS.
- MUX_DIV, 1000: clocks per digit-multiplex slot, ≥2.
- SCROLL_DIV, 5000000: clocks per scroll step, ≥2.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous buffer flush; same effect as reset on buffer, state and scroll position; mux position unaffected.
- wr_valid  in  1  write request.
- wr_data  in  8  ASCII character.
- wr_ready  out  1  buffer can accept; combinational: (count < BUF_DEPTH) && !clr.
- scroll_en  in  1  allows scrolling when text exceeds NUM_DIGITS.
- seg  out  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-high, registered.
- dig  out  NUM_DIGITS  one-hot digit enable, registered; dig[0] = leftmost.
- scrolling  out  1  high in SCROLL state, registered.

## Operation
- Write: a char is accepted on a cycle with wr_valid && wr_ready. It is stored at buf[count], and count increments by 1 (width $clog2(BUF_DEPTH+1)).
- Writes when the buffer is full are ignored; no overwrite.
- Case folding: 'a'–'z' fold to 'A'–'Z' at decode. Stored data is unmodified.
- Decode:
  - 'A'–'Z' use the team letter glyph set, e.g. 'C'=1001110, 'E'=1001111, 'H'=0110111, 'L'=0001110.
  - Space and all other codes decode to 0000000.
- State machine, with next-state evaluated every cycle:
  - EMPTY: count==0. All digits blank.
  - STATIC: 0<count≤NUM_DIGITS, or count>NUM_DIGITS with scroll_en=0. Digit i shows buf[i] if i<count, else blank. Window start is held.
  - SCROLL: count>NUM_DIGITS and scroll_en=1. Digit i shows buf[(start+i) mod count].
  - clr or rst from any state → EMPTY. Start resets to 0 and the scroll counter resets to 0.
- Scroll step:
  - Scroll counter runs only in SCROLL and counts 0..SCROLL_DIV-1.
  - At SCROLL_DIV-1, start advances by 1, wrapping from count-1 to 0.
  - Leaving SCROLL because scroll_en falls freezes start and the counter. Re-entry resumes from the frozen values.
- Modulo is computed by compare-and-subtract (start+i < 2·count always holds), so no divider is used.
- Writes during SCROLL extend count immediately. The window picks up the new char on the next mux slot.

## Timing
- Reset values:
  - seg=0, dig=0, scrolling=0.
  - count=0, start=0, mux counter=0, digit index=0.
  - State EMPTY.
- Mux counter counts 0..MUX_DIV-1. A tick occurs when it equals MUX_DIV-1.
- On each tick, register seg ← glyph of the current digit index and dig ← one-hot(index). Then the index advances, wrapping NUM_DIGITS-1 → 0.
- The first non-zero dig appears MUX_DIV cycles after rst deasserts, with dig[0] set.
- Write-to-display latency: the char is visible at its digit at the first tick that selects that digit after acceptance. Worst case is NUM_DIGITS·MUX_DIV cycles.
- A scroll step takes effect on digits at their next tick. There is no tearing guarantee across digits within one refresh frame.
- Simultaneous clr and wr_valid: clr wins and the write is not accepted, because wr_ready is 0.
- rst mid-scroll: all registers return to reset values on the next edge.

## Configuration
- SEG_DIGITS_EN
  - Defined: '0'–'9' decode to numerals, e.g. '0'=1111110, '1'=0110000, '8'=1111111.
  - Undefined: '0'–'9' decode blank, and no numeral glyph logic is built.

## Test plan
- Reset, then write "HI" with NUM_DIGITS=4, MUX_DIV=4:
  - state STATIC;
  - ticks produce dig=0001/seg=0110111, dig=0010/seg=0110000, then dig=0100 and dig=1000 both with seg=0.
- Write 16 chars, then hold wr_valid for a 17th: wr_ready=0 and count stays 16. Assert clr: count=0, state EMPTY, and all digits show blank on the next frame.
- Write "HELLO " with scroll_en=1 and SCROLL_DIV=8:
  - scrolling=1;
  - start steps 0→1→…→5→0 every 8 cycles;
  - with start=4, the window shows "O HE".
- Deassert scroll_en mid-scroll: start is frozen and scrolling=0. Reassert: stepping resumes from the frozen start.
- Write 'e' and 'c': they display as 'E' (1001111) and 'C' (1001110).
- With SEG_DIGITS_EN, '8' shows 1111111; without it, '8' shows 0000000. Assert rst mid-scroll: all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/ascii_scroll_display.sv
// rtl/ascii_scroll_display.sv - time-multiplexed ASCII text driver for a row of 7-segment digits
//
// Characters are appended to a circular buffer through a valid/ready port and
// shown either statically or scrolled right-to-left across NUM_DIGITS digits
// that share one segment bus.
//
// Optional feature macro: SEG_DIGITS_EN (adds numeral glyphs for '0'-'9').
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   clr        synchronous flush of buffer, state and scroll position
//   wr_valid   write request
//   wr_data    ASCII character to append
//   wr_ready   buffer can accept a character this cycle
//   scroll_en  allow scrolling when the text is longer than the display
//   seg        segments {a,b,c,d,e,f,g}, active high, registered
//   dig        one-hot digit enable, dig[0] = leftmost, registered
//   scrolling  high while in the scroll state, registered
module ascii_scroll_display #(
    parameter int NUM_DIGITS = 4,
    parameter int BUF_DEPTH  = 16,
    parameter int MUX_DIV    = 1000,
    parameter int SCROLL_DIV = 5000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_valid,
    input  logic [7:0]            wr_data,
    output logic                  wr_ready,
    input  logic                  scroll_en,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig,
    output logic                  scrolling
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MW = $clog2(MUX_DIV);
    localparam int SW = $clog2(SCROLL_DIV);

    localparam logic [CW-1:0]         DEPTH_C     = CW'(BUF_DEPTH);
    localparam logic [CW-1:0]         NDIG_C      = CW'(NUM_DIGITS);
    localparam logic [DW-1:0]         DIG_LAST    = DW'(NUM_DIGITS - 1);
    localparam logic [MW-1:0]         MUX_LAST    = MW'(MUX_DIV - 1);
    localparam logic [SW-1:0]         SCROLL_LAST = SW'(SCROLL_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE     = NUM_DIGITS'(1);
    localparam logic [7:0]            BLANK_CHAR  = 8'h20;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_STATIC,
        ST_SCROLL
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [7:0]      char_mem [0:BUF_DEPTH-1];
    logic [CW-1:0]   count;
    logic [CW-1:0]   start;
    logic [SW-1:0]   scroll_cnt;
    logic [MW-1:0]   mux_cnt;
    logic [DW-1:0]   idx;

    logic            wr_fire;
    logic [CW:0]     idx_w;
    logic [CW:0]     start_w;
    logic [CW:0]     count_w;
    logic [CW:0]     pos_sum;
    logic [CW:0]     pos_wrap;
    logic [7:0]      disp_char;

    // Glyph lookup; lower-case letters share the upper-case glyphs.
    function automatic logic [6:0] glyph(input logic [7:0] ch);
        logic [7:0] c;
        c = ch;
        if (c >= "a" && c <= "z") begin
            c = c - 8'h20;
        end
        case (c)
            "A":     glyph = 7'b1110111;
            "B":     glyph = 7'b0011111;
            "C":     glyph = 7'b1001110;
            "D":     glyph = 7'b0111101;
            "E":     glyph = 7'b1001111;
            "F":     glyph = 7'b1000111;
            "G":     glyph = 7'b1011110;
            "H":     glyph = 7'b0110111;
            "I":     glyph = 7'b0110000;
            "J":     glyph = 7'b0111100;
            "K":     glyph = 7'b1010111;
            "L":     glyph = 7'b0001110;
            "M":     glyph = 7'b1010100;
            "N":     glyph = 7'b0010101;
            "O":     glyph = 7'b1111110;
            "P":     glyph = 7'b1100111;
            "Q":     glyph = 7'b1110011;
            "R":     glyph = 7'b0000101;
            "S":     glyph = 7'b1011011;
            "T":     glyph = 7'b0001111;
            "U":     glyph = 7'b0111110;
            "V":     glyph = 7'b0011100;
            "W":     glyph = 7'b0101010;
            "X":     glyph = 7'b0110110;
            "Y":     glyph = 7'b0111011;
            "Z":     glyph = 7'b1101101;
`ifdef SEG_DIGITS_EN
            "0":     glyph = 7'b1111110;
            "1":     glyph = 7'b0110000;
            "2":     glyph = 7'b1101101;
            "3":     glyph = 7'b1111001;
            "4":     glyph = 7'b0110011;
            "5":     glyph = 7'b1011011;
            "6":     glyph = 7'b1011111;
            "7":     glyph = 7'b1110000;
            "8":     glyph = 7'b1111111;
            "9":     glyph = 7'b1111011;
`endif
            default: glyph = 7'b0000000;
        endcase
    endfunction

    // clr blocks acceptance so a simultaneous write cannot survive the flush.
    assign wr_ready = (count < DEPTH_C) && !clr;
    assign wr_fire  = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            char_mem[IW'(count)] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count      <= '0;
            start      <= '0;
            scroll_cnt <= '0;
        end else begin
            if (wr_fire) begin
                count <= count + 1'b1;
            end
            // Outside SCROLL both start and the step counter hold, so
            // re-entering scroll resumes exactly where it paused.
            if (state == ST_SCROLL) begin
                if (scroll_cnt == SCROLL_LAST) begin
                    scroll_cnt <= '0;
                    start      <= (start + 1'b1 >= count) ? '0 : start + 1'b1;
                end else begin
                    scroll_cnt <= scroll_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            scrolling <= 1'b0;
        end else begin
            state     <= state_next;
            scrolling <= (state_next == ST_SCROLL);
        end
    end

    always_comb begin
        state_next = state;
        if (clr || count == '0) begin
            state_next = ST_EMPTY;
        end else if (count > NDIG_C && scroll_en) begin
            state_next = ST_SCROLL;
        end else begin
            state_next = ST_STATIC;
        end
    end

    assign idx_w   = {{(CW + 1 - DW){1'b0}}, idx};
    assign start_w = {1'b0, start};
    assign count_w = {1'b0, count};

    // In SCROLL start < count and idx < NUM_DIGITS < count, so the sum is
    // below 2*count and one conditional subtract gives the modulo.
    always_comb begin
        pos_sum   = start_w + idx_w;
        pos_wrap  = (pos_sum >= count_w) ? (pos_sum - count_w) : pos_sum;
        disp_char = BLANK_CHAR;
        case (state)
            ST_STATIC: begin
                if (idx_w < count_w) begin
                    disp_char = char_mem[IW'(idx_w)];
                end
            end
            ST_SCROLL: disp_char = char_mem[IW'(pos_wrap)];
            default:   disp_char = BLANK_CHAR;
        endcase
    end

    // Multiplexer: mux position is deliberately not affected by clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_cnt <= '0;
            idx     <= '0;
            seg     <= '0;
            dig     <= '0;
        end else if (mux_cnt == MUX_LAST) begin
            mux_cnt <= '0;
            seg     <= glyph(disp_char);
            dig     <= DIG_ONE << idx;
            idx     <= (idx == DIG_LAST) ? '0 : idx + 1'b1;
        end else begin
            mux_cnt <= mux_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ascii_scroll_display.sv
// tb/tb_ascii_scroll_display.sv - directed self-checking bench for ascii_scroll_display
module tb_ascii_scroll_display;

    localparam logic [6:0] G_BL = 7'b0000000;
    localparam logic [6:0] G_H  = 7'b0110111;
    localparam logic [6:0] G_I  = 7'b0110000;
    localparam logic [6:0] G_E  = 7'b1001111;
    localparam logic [6:0] G_L  = 7'b0001110;
    localparam logic [6:0] G_O  = 7'b1111110;
    localparam logic [6:0] G_C  = 7'b1001110;
`ifdef SEG_DIGITS_EN
    localparam logic [6:0] G_8  = 7'b1111111;
`else
    localparam logic [6:0] G_8  = 7'b0000000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       scroll_en = 1'b0;
    logic [6:0] seg;
    logic [3:0] dig;
    logic       scrolling;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Ticks m = 2..13 of "HELLO " scrolling, hand-derived per digit.
    logic [6:0] exp_scroll [12] = '{G_E, G_L, G_O, G_E, G_L, G_O,
                                    G_H, G_L, G_BL, G_H, G_L, G_BL};
    // Ticks m = 26..31 after resuming.
    logic [6:0] exp_resume [6] = '{G_E, G_L, G_O, G_E, G_L, G_O};

    ascii_scroll_display #(
        .NUM_DIGITS(4),
        .BUF_DEPTH (16),
        .MUX_DIV   (4),
        .SCROLL_DIV(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .scroll_en(scroll_en),
        .seg      (seg),
        .dig      (dig),
        .scrolling(scrolling)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_tick(input string tag, input int t, input logic [3:0] d, input logic [6:0] s);
        wait_to(t);
        check({tag, "_dig"}, {28'd0, dig}, {28'd0, d});
        check({tag, "_seg"}, {25'd0, seg}, {25'd0, s});
    endtask

    initial begin
        // Reset values
        adv(2);
        check("rst_seg", {25'd0, seg}, 32'd0);
        check("rst_dig", {28'd0, dig}, 32'd0);
        check("rst_scrolling", {31'd0, scrolling}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Write "HI", static display
        rst = 1'b0; wr_valid = 1'b1; wr_data = "H"; cyc = 0;
        adv(1); wr_data = "I";
        adv(1); wr_valid = 1'b0;
        wait_to(3);
        check("first_dig_not_yet", {28'd0, dig}, 32'd0);
        check_tick("hi_d0", 4, 4'b0001, G_H);
        check("hi_static", {31'd0, scrolling}, 32'd0);
        check_tick("hi_d1", 8, 4'b0010, G_I);
        check_tick("hi_d2", 12, 4'b0100, G_BL);
        check_tick("hi_d3", 16, 4'b1000, G_BL);

        // Fill to 16, then try a 17th write
        wr_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            wr_data = 8'h41 + 8'(i);
            adv(1);
        end
        check("ready_at_15", {31'd0, wr_ready}, 32'd1);
        wr_data = "Q";
        adv(1);
        check("ready_at_16", {31'd0, wr_ready}, 32'd0);
        wr_data = "Z";
        adv(3);
        check("ready_full_held", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b0;
        check_tick("full_d0", 36, 4'b0001, G_H);
        check_tick("full_d1", 40, 4'b0010, G_I);

        // clr together with a write: clr wins
        clr = 1'b1; wr_valid = 1'b1; wr_data = "H";
        #1;
        check("clr_ready", {31'd0, wr_ready}, 32'd0);
        adv(1);
        clr = 1'b0; wr_valid = 1'b0;
        #1;
        check("after_clr_ready", {31'd0, wr_ready}, 32'd1);
        check_tick("clr_d2", 44, 4'b0100, G_BL);
        check_tick("clr_d3", 48, 4'b1000, G_BL);
        check_tick("clr_d0", 52, 4'b0001, G_BL);
        check_tick("clr_d1", 56, 4'b0010, G_BL);

        // Case folding and the numeral option
        wr_valid = 1'b1; wr_data = "e";
        adv(1); wr_data = "c";
        adv(1); wr_data = "8";
        adv(1); wr_valid = 1'b0;
        check_tick("num8_d2", 60, 4'b0100, G_8);
        check_tick("blank_d3", 64, 4'b1000, G_BL);
        check_tick("fold_e_d0", 68, 4'b0001, G_E);
        check_tick("fold_c_d1", 72, 4'b0010, G_C);

        // Re-align with a reset, then scroll "HELLO "
        rst = 1'b1;
        adv(1);
        check("rst2_dig", {28'd0, dig}, 32'd0);
        rst = 1'b0; scroll_en = 1'b1; wr_valid = 1'b1; wr_data = "H"; cyc = 0;
        adv(1); wr_data = "E";
        adv(1); wr_data = "L";
        adv(1); wr_data = "L";
        adv(1); wr_data = "O";
        adv(1); wr_data = " ";
        adv(1); wr_valid = 1'b0;
        wait_to(8);
        check("scroll_on", {31'd0, scrolling}, 32'd1);
        for (int m = 2; m <= 13; m++) begin
            check_tick($sformatf("scroll_m%0d", m), 4 * m,
                       4'b0001 << ((m - 1) % 4), exp_scroll[m - 2]);
        end

        // Pause scrolling: static window shows the first chars
        scroll_en = 1'b0;
        adv(1);
        check("pause_scrolling", {31'd0, scrolling}, 32'd0);
        check_tick("pause_d1", 56, 4'b0010, G_E);
        check_tick("pause_d2", 60, 4'b0100, G_L);
        check_tick("pause_d3", 64, 4'b1000, G_L);
        check_tick("pause_d0", 68, 4'b0001, G_H);
        check_tick("pause_late_d0", 100, 4'b0001, G_H);

        // Resume from the frozen start and step counter
        scroll_en = 1'b1;
        for (int m = 26; m <= 31; m++) begin
            check_tick($sformatf("resume_m%0d", m), 4 * m,
                       4'b0001 << ((m - 1) % 4), exp_resume[m - 26]);
            if (m == 26) begin
                check("resume_scrolling", {31'd0, scrolling}, 32'd1);
            end
        end

        // Reset mid-scroll
        rst = 1'b1;
        adv(1);
        check("midrst_seg", {25'd0, seg}, 32'd0);
        check("midrst_dig", {28'd0, dig}, 32'd0);
        check("midrst_scrolling", {31'd0, scrolling}, 32'd0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
